// File: rtl/instruction_fetch_if.sv
// Fetch-side bus bundle: RAM address/enable/data plus the decoder-facing instruction handshake.
// Handshake: an entry transfers on any rising edge where instr_valid && instr_ready; instr_valid never depends on instr_ready.
interface instruction_fetch_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] mem_address;
    logic                  mem_enable;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [DATA_WIDTH-1:0] instr_data;
    logic [ADDR_WIDTH-1:0] instr_addr;

    modport master (
        output mem_address, mem_enable, instr_valid, instr_data, instr_addr,
        input  mem_data, instr_ready
    );

    modport slave (
        input  mem_address, mem_enable, instr_valid, instr_data, instr_addr,
        output mem_data, instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch unit: owns the PC, reads the instruction RAM and buffers {addr, data} pairs
// in a small prefetch queue feeding the decoder; supports start, redirect/flush and end-of-memory.
module instruction_fetch #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 128,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         redirect_valid,
    input  logic [ADDR_WIDTH-1:0]        redirect_addr,
    instruction_fetch_if.master          bus,
    output logic                         done,
    output logic [1:0]                   dbg_state,
    output logic [$clog2(QUEUE_DEPTH):0] dbg_count
);
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CW-1:0]         FULL      = CW'(QUEUE_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   MEM_LIMIT = (ADDR_WIDTH + 1)'(MEM_DEPTH);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] pc;
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic [DATA_WIDTH-1:0] data_q [QUEUE_DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q [QUEUE_DEPTH];
    logic                  push;
    logic                  pop;

    // A redirect cycle never fetches: the PC is about to be replaced.
    assign push = (state == S_FETCH) && (count < FULL) && !redirect_valid;
    assign pop  = bus.instr_valid && bus.instr_ready;

    assign bus.mem_enable  = push;
    assign bus.mem_address = pc;
    assign bus.instr_valid = (count != '0);
    assign bus.instr_data  = bus.instr_valid ? data_q[rd_ptr] : '0;
    assign bus.instr_addr  = bus.instr_valid ? addr_q[rd_ptr] : '0;

    assign done      = (state == S_DONE) && (count == '0);
    assign dbg_state = state;
    assign dbg_count = count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            pc     <= '0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            // Flush wins over any pop this cycle; the decoder still consumed that entry.
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            pc     <= redirect_addr;
            state  <= ({1'b0, redirect_addr} < MEM_LIMIT) ? S_FETCH : S_DONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (push) begin
                        if (pc == LAST_ADDR) state <= S_DONE;
                        else                 pc    <= pc + ADDR_WIDTH'(1);
                    end
                end
                default: ;
            endcase
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage needs no reset: entries are only visible while counted.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= bus.mem_data;
            addr_q[wr_ptr] <= pc;
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a random phase, checked every cycle
// against a queue-based reference model of the fetch/prefetch behaviour.
module tb_instruction_fetch;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_END  = 2;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       redirect_valid;
    logic [7:0] redirect_addr;
    logic       done;
    logic [1:0] dbg_state;
    logic [2:0] dbg_count;

    logic [7:0]  ram [0:255];
    logic [15:0] exp_q [$];
    logic [7:0]  model_pc;
    int          mode;
    int          total;
    int          passed;
    int          failed;

    instruction_fetch_if #(.ADDR_WIDTH(8), .DATA_WIDTH(8)) bus ();

    instruction_fetch #(
        .ADDR_WIDTH(8), .DATA_WIDTH(8), .MEM_DEPTH(128), .QUEUE_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .start(start),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .bus(bus),
        .done(done),
        .dbg_state(dbg_state),
        .dbg_count(dbg_count)
    );

    // RAM model: garbage when disabled so an illegal sample shows up as wrong data.
    assign bus.mem_data = bus.mem_enable ? ram[bus.mem_address] : 8'hA5;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        model_pc = 8'd0;
        mode     = M_IDLE;
    endtask

    task automatic check_outputs(input logic rv);
        logic [15:0] head;
        logic        fetch_now;
        head      = (exp_q.size() > 0) ? exp_q[0] : 16'h0000;
        fetch_now = (mode == M_RUN) && (exp_q.size() < 4) && !rv;
        chk("mem_address", {24'd0, bus.mem_address}, {24'd0, model_pc});
        chk("mem_enable", {31'd0, bus.mem_enable}, {31'd0, fetch_now});
        chk("instr_valid", {31'd0, bus.instr_valid}, (exp_q.size() > 0) ? 32'd1 : 32'd0);
        chk("instr_addr", {24'd0, bus.instr_addr}, {24'd0, head[15:8]});
        chk("instr_data", {24'd0, bus.instr_data}, {24'd0, head[7:0]});
        chk("done", {31'd0, done}, ((mode == M_END) && (exp_q.size() == 0)) ? 32'd1 : 32'd0);
        chk("count", {29'd0, dbg_count}, 32'(exp_q.size()));
    endtask

    task automatic step(input logic st, input logic rv, input logic [7:0] ra, input logic rdy);
        logic fetch_now;
        logic pop_now;
        @(negedge clk);
        start          = st;
        redirect_valid = rv;
        redirect_addr  = ra;
        bus.instr_ready = rdy;
        #1;
        check_outputs(rv);
        fetch_now = (mode == M_RUN) && (exp_q.size() < 4) && !rv;
        pop_now   = (exp_q.size() > 0) && rdy;
        @(posedge clk);
        if (rv) begin
            exp_q.delete();
            model_pc = ra;
            mode     = (int'(ra) < 128) ? M_RUN : M_END;
        end else begin
            if (pop_now) void'(exp_q.pop_front());
            if (fetch_now) begin
                exp_q.push_back({model_pc, ram[model_pc]});
                if (model_pc == 8'd127) mode = M_END;
                else                    model_pc = model_pc + 8'd1;
            end
            if (mode == M_IDLE && st) mode = M_RUN;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        start = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'd0; bus.instr_ready = 1'b0;
        #1;
        model_reset();
        check_outputs(1'b0);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        total = 0; passed = 0; failed = 0;
        for (int i = 0; i < 256; i++) ram[i] = 8'($urandom_range(0, 255));
        ram[0] = 8'd4; ram[1] = 8'd3; ram[2] = 8'd8; ram[3] = 8'd5;
        reset_n = 1'b0;
        start = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'd0; bus.instr_ready = 1'b0;
        model_reset();
        #1;
        check_outputs(1'b0);
        do_reset();

        // Basic fetch with decoder always ready
        step(1, 0, 0, 1);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 1);

        // Back-pressure: fill the queue, then drain
        do_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // Redirect flush with two entries held
        do_reset();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 8'd2, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // End of memory, then restart by redirect
        step(0, 1, 8'd126, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);
        step(0, 1, 8'd0, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // Start and out-of-range redirect together in IDLE
        do_reset();
        step(1, 1, 8'd200, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // Push and pop together at count 2
        step(0, 1, 8'd10, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // Pop accepted in a redirect cycle
        step(0, 1, 8'd40, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 8'd60, 1);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

        // Random traffic
        for (int i = 0; i < 360; i++) begin
            logic       st;
            logic       rv;
            logic [7:0] ra;
            logic       rdy;
            if (i % 120 == 119) do_reset();
            st  = ($urandom_range(0, 9) == 0);
            rv  = ($urandom_range(0, 19) == 0);
            ra  = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(118, 140)) : 8'($urandom_range(0, 255));
            rdy = ($urandom_range(0, 3) != 0);
            step(st, rv, ra, rdy);
        end

        // Asynchronous reset while three entries are queued
        step(0, 1, 8'd20, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("async_enable", {31'd0, bus.mem_enable}, 32'd0);
        chk("async_address", {24'd0, bus.mem_address}, 32'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
        step(1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch unit directly upstream of the instruction RAM: owns the program counter and drives the RAM's 8-bit address and enable. It samples the combinationally read 8-bit data word and buffers fetched words, tagged with their addresses, in a small prefetch queue. The queue hands instructions to the decoder over a valid/ready handshake. It supports start, jump-style redirect with queue flush, and a terminal DONE state at the end of memory.

## Interface
- ADDR_WIDTH, 8, width of PC and RAM address
- DATA_WIDTH, 8, instruction word width
- MEM_DEPTH, 128, number of valid RAM words; fetch stops after address MEM_DEPTH-1
- QUEUE_DEPTH, 4, prefetch queue entries (power of two)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; in IDLE begins fetching from address 0
- redirect_valid  in  1  pulse; flush queue and jump
- redirect_addr  in  ADDR_WIDTH  jump target
- mem_address  out  ADDR_WIDTH  to RAM address, equals PC at all times
- mem_enable  out  1  to RAM enable
- mem_data  in  DATA_WIDTH  from RAM data; high-Z when mem_enable=0, never sampled then
- instr_valid  out  1  queue non-empty
- instr_ready  in  1  decoder accepts head entry
- instr_data  out  DATA_WIDTH  head instruction, 0 when instr_valid=0
- instr_addr  out  ADDR_WIDTH  address of head instruction, 0 when instr_valid=0
- done  out  1  state DONE and queue empty

## Operation
- States: IDLE, FETCH, DONE. Reset → IDLE, PC=0, count=0, read/write pointers 0.
- Reset values: mem_address 0, mem_enable 0, instr_valid 0, instr_data 0, instr_addr 0, done 0.
- IDLE: start=1 → FETCH, PC unchanged at 0. Start is ignored in FETCH and DONE.
- mem_enable (combinational) = state==FETCH && count<QUEUE_DEPTH && !redirect_valid.
- Fetch cycle (mem_enable=1): push {PC, mem_data} at the clock edge and increment PC.
  - If PC was MEM_DEPTH-1, go to DONE and hold PC at MEM_DEPTH-1 (no wrap).
- Pop: instr_valid && instr_ready advances the read pointer.
- Push and pop in the same cycle leave count unchanged.
- There is no same-cycle bypass: when full, fetch resumes the cycle after a pop.
- Redirect (any state, including IDLE and DONE; priority over start, push and pop):
  - Queue cleared (count=0, pointers 0) and PC=redirect_addr.
  - State becomes FETCH if redirect_addr<MEM_DEPTH, else DONE.
  - A pop accepted in the redirect cycle is still consumed by the decoder; the queue clears regardless.
- done = state==DONE && count==0. Remaining entries drain normally in DONE.
- count is a $clog2(QUEUE_DEPTH)+1 bit field. Pointers wrap modulo QUEUE_DEPTH.

## Timing
- Start sampled at edge 0 → FETCH in cycle 1. mem_enable=1 in cycle 1, entry captured at edge 1, instr_valid=1 in cycle 2.
- Sustained throughput is 1 instruction/cycle with instr_ready held high.
- Redirect sampled at edge N → instr_valid=0 in cycle N+1 with mem_enable=1 at redirect_addr, first new instruction valid in cycle N+2.
- Redirect penalty is 2 cycles.
- Full queue: mem_enable=0 for that cycle. After a pop at edge N, mem_enable=1 in cycle N+1.
- reset_n low clears all state immediately, without waiting for clk. Outputs go to reset values asynchronously.
- After reset_n rises, the block waits in IDLE for start.

## Test plan
- **Basic fetch:** RAM holds 4,3,8,5 at addresses 0–3, instr_ready=1, pulse start → instr_valid from cycle 2; data 4,3,8,5 with addr 0,1,2,3 on consecutive cycles.
- **Back-pressure:** instr_ready=0 after start → exactly 4 fetches, then mem_enable=0 with PC=4 and count=4. Raise instr_ready → 4,3,8,5 delivered in order, and fetch of address 4 resumes the cycle after the first pop.
- **Redirect flush:** queue holding addresses 0–1, then redirect_addr=2 → instr_valid=0 next cycle; next delivered entry is addr 2, data 8, followed by addr 3, data 5.
- **End of memory:** redirect_addr=126, instr_ready=1 → fetches 126 and 127 only, then DONE. mem_enable stays 0 and done=1 after both entries are popped. A later redirect to 0 restarts fetching.
- **Simultaneous and out-of-range events:** start and redirect_addr=200 in the same IDLE cycle → DONE and no fetch (mem_enable never 1), done=1 next cycle. Push+pop in the same cycle at count=2 → count stays 2.
- **Reset mid-operation:** drop reset_n between clk edges while queue holds 3 entries → instr_valid, mem_enable and mem_address are 0 before the next edge. After release, no fetch occurs until start.
